// File: rtl/des_iter_core.sv
// Iterative single-DES core: IP, 16 Feistel rounds with an on-the-fly key schedule, IP^-1.
// ROUNDS_PER_CYCLE chained round stages are evaluated per clock.
module des_iter_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  input  logic        decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  localparam int unsigned RPC   = ROUNDS_PER_CYCLE;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(RPC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(16 - RPC);

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned IPI_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Each S-box is 64 nibbles, row-major (row = b1b6, col = b2..b5), first entry in the top nibble.
  localparam logic [255:0] SBOX_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] res;
    for (int j = 0; j < 64; j++) res[6'(63 - j)] = x[6'(64 - IP_T[6'(j)])];
    return res;
  endfunction

  function automatic logic [63:0] perm_ipi(input logic [63:0] x);
    logic [63:0] res;
    for (int j = 0; j < 64; j++) res[6'(63 - j)] = x[6'(64 - IPI_T[6'(j)])];
    return res;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] res;
    for (int j = 0; j < 56; j++) res[6'(55 - j)] = x[6'(64 - PC1_T[6'(j)])];
    return res;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] res;
    for (int j = 0; j < 48; j++) res[6'(47 - j)] = x[6'(56 - PC2_T[6'(j)])];
    return res;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r_in, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] res;
    logic [5:0]  b;
    logic [7:0]  base;
    for (int j = 0; j < 48; j++) x[6'(47 - j)] = r_in[5'(32 - E_T[6'(j)])];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b    = x[6'(47 - 6 * i) -: 6];
      base = ~{b[5], b[0], b[4:1], 2'b00};
      s[5'(31 - 4 * i) -: 4] = SBOX_T[3'(i)][base -: 4];
    end
    for (int j = 0; j < 32; j++) res[5'(31 - j)] = s[5'(32 - P_T[5'(j)])];
    return res;
  endfunction

  function automatic logic single_shift(input logic [CNT_W-1:0] n);
    return (n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [31:0]      l, r;
  logic [27:0]      c, d;
  logic [CNT_W-1:0] cnt;
  logic             dec_mode;

  logic [31:0] l_s [RPC+1];
  logic [31:0] r_s [RPC+1];
  logic [27:0] c_s [RPC+1];
  logic [27:0] d_s [RPC+1];

  assign l_s[0] = l;
  assign r_s[0] = r;
  assign c_s[0] = c;
  assign d_s[0] = d;

  // Decrypt walks the schedule backwards: C/D after PC-1 already equal C16/D16.
  for (genvar k = 0; k < RPC; k++) begin : g_round
    logic [CNT_W-1:0] rnd;
    logic [27:0]      c_n, d_n;
    logic [47:0]      subkey;
    always_comb begin
      rnd = cnt + CNT_W'(k + 1);
      c_n = c_s[k];
      d_n = d_s[k];
      if (dec_mode) begin
        if (rnd == 5'd1) begin
          c_n = c_s[k];
          d_n = d_s[k];
        end else if (single_shift(rnd)) begin
          c_n = {c_s[k][0], c_s[k][27:1]};
          d_n = {d_s[k][0], d_s[k][27:1]};
        end else begin
          c_n = {c_s[k][1:0], c_s[k][27:2]};
          d_n = {d_s[k][1:0], d_s[k][27:2]};
        end
      end else if (single_shift(rnd)) begin
        c_n = {c_s[k][26:0], c_s[k][27]};
        d_n = {d_s[k][26:0], d_s[k][27]};
      end else begin
        c_n = {c_s[k][25:0], c_s[k][27:26]};
        d_n = {d_s[k][25:0], d_s[k][27:26]};
      end
      subkey = perm_pc2({c_n, d_n});
    end
    assign c_s[k+1] = c_n;
    assign d_s[k+1] = d_n;
    assign l_s[k+1] = r_s[k];
    assign r_s[k+1] = l_s[k] ^ feistel(r_s[k], subkey);
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= 64'h0;
      l         <= 32'h0;
      r         <= 32'h0;
      c         <= 28'h0;
      d         <= 28'h0;
      cnt       <= '0;
      dec_mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dec_mode <= decrypt;
            {l, r}   <= perm_ip(data_in);
            {c, d}   <= perm_pc1(key_in);
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          l   <= l_s[RPC];
          r   <= r_s[RPC];
          c   <= c_s[RPC];
          d   <= d_s[RPC];
          cnt <= cnt + CNT_STEP;
          if (cnt == CNT_LAST) begin
            data_out  <= perm_ipi({r_s[RPC], l_s[RPC]});
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: one instance per legal ROUNDS_PER_CYCLE, checked against a
// subkey-table DES reference model plus published known-answer vectors.
module tb_des_iter_core;

  localparam int NU = 5;
  localparam int RPC_TAB [NU] = '{1, 2, 4, 8, 16};

  logic        clk = 1'b0;
  logic        rst_a      [NU];
  logic        in_valid_a [NU];
  logic        in_ready_a [NU];
  logic [63:0] key_a      [NU];
  logic [63:0] data_a     [NU];
  logic        dec_a      [NU];
  logic        out_valid_a[NU];
  logic        out_ready_a[NU];
  logic [63:0] dout_a     [NU];
  logic        busy_a     [NU];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    des_iter_core #(.ROUNDS_PER_CYCLE(RPC_TAB[g])) u_dut (
      .clk      (clk),
      .reset    (rst_a[g]),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_a[g]),
      .key_in   (key_a[g]),
      .data_in  (data_a[g]),
      .decrypt  (dec_a[g]),
      .out_valid(out_valid_a[g]),
      .out_ready(out_ready_a[g]),
      .data_out (dout_a[g]),
      .busy     (busy_a[g])
    );
  end

  // ---------------- reference model (FIPS 46-3, precomputed subkey table) ----------------
  int ip_t[$] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                  64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int ipi_t[$] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                   37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                   34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int e_t[$] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                 16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int p_t[$] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                 2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                   60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                   29,21,13,5,28,20,12,4};
  int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shifts[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sbox[8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Output bit j (1-based, MSB first) takes input bit tab[j]; result right-justified.
  function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int tab[$]);
    logic [63:0] res = '0;
    foreach (tab[j]) res = {res[62:0], x[6'(in_w - tab[j])]};
    return res;
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] blk,
                                            input logic dec);
    logic [63:0] t;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] l, r, sv, f, tmp;
    logic [47:0] x;
    logic [5:0]  six;
    t = perm(key, 64, pc1_t);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < shifts[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = perm({8'h0, c, d}, 56, pc2_t);
      ks[i] = t[47:0];
    end
    t = perm(blk, 64, ip_t);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      t = perm({32'h0, r}, 32, e_t);
      x = t[47:0] ^ (dec ? ks[15 - i] : ks[i]);
      sv = '0;
      for (int j = 0; j < 8; j++) begin
        six = x[47 - 6 * j -: 6];
        sv = {sv[27:0], 4'(sbox[j][{six[5], six[0]} * 16 + six[4:1]])};
      end
      t = perm({32'h0, sv}, 32, p_t);
      f = t[31:0];
      tmp = r;
      r = l ^ f;
      l = tmp;
    end
    return perm({r, l}, 64, ipi_t);
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Presents a request, keeps in_valid high with junk during RUN, and stops in DONE.
  task automatic do_op(input int u, input logic [63:0] key, input logic [63:0] blk,
                       input logic dec, output logic [63:0] res, output int lat,
                       output bit timeout);
    int n = 0;
    timeout = 0;
    while (!in_ready_a[u] && n < 50) begin
      step();
      n++;
    end
    in_valid_a[u] = 1'b1;
    key_a[u] = key;
    data_a[u] = blk;
    dec_a[u] = dec;
    step();
    key_a[u] = rnd64();
    data_a[u] = rnd64();
    dec_a[u] = ~dec;
    n = 0;
    while (!out_valid_a[u] && n < 40) begin
      step();
      n++;
    end
    in_valid_a[u] = 1'b0;
    timeout = !out_valid_a[u];
    lat = n;
    res = dout_a[u];
  endtask

  task automatic take(input int u);
    out_ready_a[u] = 1'b1;
    step();
    out_ready_a[u] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset(input int u);
    rst_a[u] = 1'b1;
    in_valid_a[u] = 1'b1;
    out_ready_a[u] = 1'b1;
    step();
    step();
    checks++;
    if (out_valid_a[u] !== 1'b0 || busy_a[u] !== 1'b0 || dout_a[u] !== 64'h0) begin
      errors++;
      $display("FAIL reset_state u%0d: out_valid=%b busy=%b data_out=%h, want 0/0/0",
               u, out_valid_a[u], busy_a[u], dout_a[u]);
    end
    rst_a[u] = 1'b0;
    in_valid_a[u] = 1'b0;
    out_ready_a[u] = 1'b0;
    step();
    checks++;
    if (in_ready_a[u] !== 1'b1 || busy_a[u] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release u%0d: in_ready=%b busy=%b, want 1/0", u, in_ready_a[u],
               busy_a[u]);
    end
  endtask

  task automatic test_known(input int u);
    logic [63:0] kat_key [4] = '{64'h133457799BBCDFF1, 64'h133457799BBCDFF1,
                                 64'h0E329232EA6D0D73, 64'h0F339333EB6C0C72};
    logic [63:0] kat_in  [4] = '{64'h0123456789ABCDEF, 64'h85E813540F0AB405,
                                 64'h8787878787878787, 64'h8787878787878787};
    logic [63:0] kat_out [4] = '{64'h85E813540F0AB405, 64'h0123456789ABCDEF,
                                 64'h0000000000000000, 64'h0000000000000000};
    logic        kat_dec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] res;
    int lat;
    bit to;
    for (int i = 0; i < 4; i++) begin
      do_op(u, kat_key[i], kat_in[i], kat_dec[i], res, lat, to);
      checks++;
      if (to || lat != 16 / RPC_TAB[u]) begin
        errors++;
        $display("FAIL kat_latency u%0d v%0d: %0d cycles (timeout=%0b), want %0d", u, i, lat,
                 to, 16 / RPC_TAB[u]);
      end
      checks++;
      if (res !== kat_out[i] || busy_a[u] !== 1'b1 || in_ready_a[u] !== 1'b0) begin
        errors++;
        $display("FAIL kat_result u%0d v%0d: data_out=%h busy=%b in_ready=%b, want %h/1/0",
                 u, i, res, busy_a[u], in_ready_a[u], kat_out[i]);
      end
      take(u);
      checks++;
      if (out_valid_a[u] !== 1'b0 || in_ready_a[u] !== 1'b1 || dout_a[u] !== kat_out[i]) begin
        errors++;
        $display("FAIL kat_take u%0d v%0d: out_valid=%b in_ready=%b data_out=%h, want 0/1/%h",
                 u, i, out_valid_a[u], in_ready_a[u], dout_a[u], kat_out[i]);
      end
    end
  endtask

  task automatic test_random(input int u);
    logic [63:0] key, blk, res, exp;
    logic dec;
    int lat;
    bit to;
    for (int i = 0; i < 6; i++) begin
      key = rnd64();
      blk = rnd64();
      dec = 1'($urandom_range(0, 1));
      exp = des_model(key, blk, dec);
      do_op(u, key, blk, dec, res, lat, to);
      checks++;
      if (to || lat != 16 / RPC_TAB[u] || res !== exp) begin
        errors++;
        $display("FAIL random u%0d #%0d: data_out=%h lat=%0d, want %h lat=%0d", u, i, res,
                 lat, exp, 16 / RPC_TAB[u]);
      end
      repeat ($urandom_range(0, 2)) step();
      take(u);
    end
  endtask

  task automatic test_backpressure(input int u);
    logic [63:0] key, blk, res, exp, exp2;
    int lat, n;
    bit to;
    key = rnd64();
    blk = rnd64();
    exp = des_model(key, blk, 1'b0);
    do_op(u, key, blk, 1'b0, res, lat, to);
    checks++;
    if (to || res !== exp) begin
      errors++;
      $display("FAIL bp_result u%0d: data_out=%h, want %h", u, res, exp);
    end
    in_valid_a[u] = 1'b1;
    key_a[u] = rnd64();
    data_a[u] = rnd64();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid_a[u] !== 1'b1 || dout_a[u] !== exp || in_ready_a[u] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold u%0d c%0d: out_valid=%b data_out=%h in_ready=%b, want 1/%h/0",
                 u, i, out_valid_a[u], dout_a[u], in_ready_a[u], exp);
      end
    end
    out_ready_a[u] = 1'b1;
    step();
    in_valid_a[u] = 1'b0;
    out_ready_a[u] = 1'b0;
    step();
    checks++;
    if (in_ready_a[u] !== 1'b1 || busy_a[u] !== 1'b0 || dout_a[u] !== exp) begin
      errors++;
      $display("FAIL bp_no_queue u%0d: in_ready=%b busy=%b data_out=%h, want 1/0/%h", u,
               in_ready_a[u], busy_a[u], dout_a[u], exp);
    end
    key = rnd64();
    blk = rnd64();
    exp2 = des_model(key, blk, 1'b1);
    in_valid_a[u] = 1'b1;
    key_a[u] = key;
    data_a[u] = blk;
    dec_a[u] = 1'b1;
    step();
    in_valid_a[u] = 1'b0;
    checks++;
    if (busy_a[u] !== 1'b1 || dout_a[u] !== exp) begin
      errors++;
      $display("FAIL bp_hold_in_run u%0d: busy=%b data_out=%h, want 1/%h", u, busy_a[u],
               dout_a[u], exp);
    end
    n = 0;
    while (!out_valid_a[u] && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (out_valid_a[u] !== 1'b1 || dout_a[u] !== exp2 || n != 16 / RPC_TAB[u]) begin
      errors++;
      $display("FAIL bp_next u%0d: out_valid=%b data_out=%h lat=%0d, want 1/%h/%0d", u,
               out_valid_a[u], dout_a[u], n, exp2, 16 / RPC_TAB[u]);
    end
    take(u);
  endtask

  task automatic test_back_to_back(input int u);
    logic [63:0] key, blk, res, exp;
    int lat;
    bit to;
    out_ready_a[u] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key = rnd64();
      blk = rnd64();
      exp = des_model(key, blk, 1'(i));
      do_op(u, key, blk, 1'(i), res, lat, to);
      checks++;
      if (to || res !== exp || lat != 16 / RPC_TAB[u]) begin
        errors++;
        $display("FAIL b2b_result u%0d #%0d: data_out=%h lat=%0d, want %h lat=%0d", u, i,
                 res, lat, exp, 16 / RPC_TAB[u]);
      end
      in_valid_a[u] = 1'b1;
      step();
      checks++;
      if (out_valid_a[u] !== 1'b0 || in_ready_a[u] !== 1'b1 || busy_a[u] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_one_done u%0d #%0d: out_valid=%b in_ready=%b busy=%b, want 0/1/0",
                 u, i, out_valid_a[u], in_ready_a[u], busy_a[u]);
      end
      in_valid_a[u] = 1'b0;
    end
    out_ready_a[u] = 1'b0;
  endtask

  task automatic test_reset_mid_run(input int u);
    logic [63:0] key, blk, res, exp;
    int lat;
    bit to;
    in_valid_a[u] = 1'b1;
    key_a[u] = rnd64();
    data_a[u] = rnd64();
    dec_a[u] = 1'b0;
    step();
    in_valid_a[u] = 1'b0;
    repeat (8 / RPC_TAB[u]) step();
    checks++;
    if (busy_a[u] !== 1'b1 || out_valid_a[u] !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_state u%0d: busy=%b out_valid=%b, want 1/0", u, busy_a[u],
               out_valid_a[u]);
    end
    rst_a[u] = 1'b1;
    in_valid_a[u] = 1'b1;
    out_ready_a[u] = 1'b1;
    step();
    checks++;
    if (out_valid_a[u] !== 1'b0 || dout_a[u] !== 64'h0 || in_ready_a[u] !== 1'b1 ||
        busy_a[u] !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset u%0d: out_valid=%b data_out=%h in_ready=%b busy=%b, want 0/0/1/0",
               u, out_valid_a[u], dout_a[u], in_ready_a[u], busy_a[u]);
    end
    rst_a[u] = 1'b0;
    in_valid_a[u] = 1'b0;
    out_ready_a[u] = 1'b0;
    step();
    key = rnd64();
    blk = rnd64();
    exp = des_model(key, blk, 1'b1);
    do_op(u, key, blk, 1'b1, res, lat, to);
    checks++;
    if (to || res !== exp || lat != 16 / RPC_TAB[u]) begin
      errors++;
      $display("FAIL post_reset_op u%0d: data_out=%h lat=%0d, want %h lat=%0d", u, res, lat,
               exp, 16 / RPC_TAB[u]);
    end
    take(u);
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst_a[u] = 1'b1;
      in_valid_a[u] = 1'b0;
      key_a[u] = '0;
      data_a[u] = '0;
      dec_a[u] = 1'b0;
      out_ready_a[u] = 1'b0;
    end
    step();
    for (int u = 0; u < NU; u++) begin
      test_reset(u);
      test_known(u);
      test_random(u);
      test_backpressure(u);
      test_back_to_back(u);
      test_reset_mid_run(u);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_iter_core.md
DES_ITER_CORE -- requirements
Module: des_iter_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, meaning DES rounds evaluated per clock; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request present on key_in/data_in/decrypt.
REQ-005 SHALL have port in_ready  output  1  core can accept a request.
REQ-006 SHALL have port key_in  input  64  DES key including parity bits; parity bits are ignored.
REQ-007 SHALL have port data_in  input  64  plaintext (encrypt) or ciphertext (decrypt) block.
REQ-008 SHALL have port decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with the request.
REQ-009 SHALL have port out_valid  output  1  data_out holds a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port data_out  output  64  result block.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement single DES per FIPS 46-3: IP, 16 Feistel rounds (E, S1-S8, P), PC-1/PC-2 key schedule, final swap and IP^-1.
REQ-014 SHALL use an FSM with states IDLE, RUN and DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-015 SHALL, in IDLE with in_valid=1: latch decrypt, IP(data_in) into L/R, PC-1(key_in) into C/D, clear round counter, enter RUN; in_valid=0 stays IDLE.
REQ-016 SHALL, in RUN, perform ROUNDS_PER_CYCLE consecutive rounds per cycle using chained combinational round stages, advancing the round counter by ROUNDS_PER_CYCLE.
REQ-017 SHALL, encrypt mode: rotate C/D left by 1 (rounds 1, 2, 9, 16) or 2 (other rounds) before deriving each subkey via PC-2.
REQ-018 SHALL, decrypt mode: apply subkeys K16..K1 by rotating C/D right, using 0 for round 1, 1 for rounds 2, 9, 16, and 2 for other rounds; no stored subkey table.
REQ-019 SHALL, on the cycle completing round 16: load data_out = IP^-1(R16||L16), enter DONE.
REQ-020 SHALL assert out_valid exactly 16/ROUNDS_PER_CYCLE cycles after the accepting edge (16 cycles at default, 1 cycle at 16).
REQ-021 SHALL hold data_out and out_valid stable in DONE until out_ready=1; on out_valid & out_ready, return to IDLE.
REQ-022 SHALL keep data_out holding the last result while in IDLE and RUN; only DONE entry or reset changes it.
REQ-023 SHALL ignore in_valid, key_in, data_in and decrypt outside IDLE (no queuing, no overwrite of the in-flight operation).
REQ-024 SHALL, back-to-back: out_ready held high yields one DONE cycle then IDLE; the next request is accepted no earlier than the cycle after the result is taken.
REQ-025 SHALL keep the round counter wide enough for 0..16; it never wraps past 16.

Reset
REQ-026 SHALL, on reset=1 at any clock edge, in any state: state=IDLE, out_valid=0, busy=0, data_out=64'h0, L/R/C/D/counter cleared, in-flight operation discarded.
REQ-027 SHALL give reset priority over in_valid and out_ready in the same cycle; in_ready = 1 on the first cycle after reset is released.

Verification
REQ-028 SHALL cover encrypt: key 133457799BBCDFF1, data 0123456789ABCDEF, decrypt=0 -> data_out 85E813540F0AB405 after 16/ROUNDS_PER_CYCLE cycles.
REQ-029 SHALL cover decrypt: same key, data 85E813540F0AB405, decrypt=1 -> data_out 0123456789ABCDEF.
REQ-030 SHALL cover encrypt: key 0E329232EA6D0D73, data 8787878787878787 -> 0000000000000000; changing only the key parity bits gives the same result.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and data_out stable; a new in_valid is ignored; the result is taken on out_ready=1.
REQ-032 SHALL cover reset mid-RUN at round 8 -> the next cycle shows out_valid=0, data_out=0, in_ready=1, and a fresh request completes correctly.
REQ-033 SHALL run REQ-028..REQ-032 for every legal ROUNDS_PER_CYCLE and check latency against REQ-020.
